// File: rtl/video_ts_render_mb.sv
// rtl/video_ts_render_mb.sv - tile/sprite TS-line renderer, 4bpp/8bpp, DRAM bitmap fetch to line buffer
//
// Purpose: fetches tile/sprite bitmap words from DRAM for one task issued by the
// tile/sprite sequencer and writes the non-transparent pixels into the TS-line RAM.
// 4bpp pixels are prefixed with the task palette; 8bpp pixels are written as-is.
//
// Ports:
//   clk, reset          video clock; synchronous active-high reset (line start, aborts task)
//   tsr_go              1-clk task start; x_coord/x_size/flip/mode8/addr/line/page/pal sampled here
//   mem_rdy             no DRAM words left to request; next task may start
//   ts_waddr/wdata/we   TS-line RAM write port
//   dram_addr/req       DRAM word address and request
//   dram_rdata          read data, valid with dram_next
//   dram_pre_next       one per accepted word, precedes dram_next
//   dram_next           read data strobe
module video_ts_render_mb #(
  parameter int XW     = 9,
  parameter int SZW    = 3,
  parameter int TRANSP = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tsr_go,
  input  logic [XW-1:0]  x_coord,
  input  logic [SZW-1:0] x_size,
  input  logic           flip,
  input  logic           mode8,
  input  logic [5:0]     addr,
  input  logic [8:0]     line,
  input  logic [7:0]     page,
  input  logic [3:0]     pal,
  output logic           mem_rdy,
  output logic [XW-1:0]  ts_waddr,
  output logic [7:0]     ts_wdata,
  output logic           ts_we,
  output logic [20:0]    dram_addr,
  output logic           dram_req,
  input  logic [15:0]    dram_rdata,
  input  logic           dram_pre_next,
  input  logic           dram_next
);
  localparam int         CW  = SZW + 3;
  localparam logic [7:0] TR8 = TRANSP[7:0];

  logic [20:0]   addr_in;
  logic [20:0]   areg;
  logic [CW-1:0] cyc;
  logic [CW-1:0] cyc_load;
  logic [XW-1:0] span;
  logic [XW-1:0] x_start;
  logic          mode_d, flip_d;
  logic [3:0]    pal_d;
  logic          mode_r, flip_r;
  logic [3:0]    pal_r;
  logic          reload;
  logic          reload_stb;
  logic [15:0]   data_r;
  logic [1:0]    pcnt;
  logic          run;
  logic          burst_end;
  logic [3:0]    pix4;
  logic [7:0]    pix8;
  logic          opaque;
  logic          unused_page;

  // Bitmap pages are 8-aligned; low page bits carry no address information.
  assign unused_page = &{1'b0, page[2:0]};

  // Word address only steps its low 7 bits, so a fetch wraps inside the 128-word bitmap line.
  assign addr_in   = {page[7:3], line, addr, 1'b0};
  assign dram_addr = tsr_go ? addr_in : {areg[20:7], areg[6:0] + {6'd0, dram_next}};

  always_ff @(posedge clk) begin
    if (reset) areg <= '0;
    else       areg <= dram_addr;
  end

  // Words left to request minus one; MSB set means nothing is left.
  assign cyc_load = mode8 ? {1'b0, x_size, 2'b11} : {2'b00, x_size, 1'b1};

  always_ff @(posedge clk) begin
    if (reset)              cyc <= '1;
    else if (tsr_go)        cyc <= cyc_load - {{(CW-1){1'b0}}, dram_pre_next};
    else if (dram_pre_next) cyc <= cyc - {{(CW-1){1'b0}}, 1'b1};
  end

  assign mem_rdy  = cyc[CW-1];
  assign dram_req = tsr_go | ~mem_rdy;

  // Task settings are parked here until the task's first word arrives, because the
  // previous task's last word may still be drawing when tsr_go comes back-to-back.
  assign span = {{(XW-CW){1'b0}}, x_size, 3'b111};

  always_ff @(posedge clk) begin
    if (tsr_go) begin
      mode_d  <= mode8;
      pal_d   <= pal;
      flip_d  <= flip;
      x_start <= x_coord + (flip ? span : '0);
    end
  end

  // tsr_go wins over a coincident dram_next: that word belongs to the previous task.
  always_ff @(posedge clk) begin
    if (reset)          reload <= 1'b0;
    else if (tsr_go)    reload <= 1'b1;
    else if (dram_next) reload <= 1'b0;
  end

  assign reload_stb = dram_next & reload;

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r <= 1'b0;
      pal_r  <= 4'd0;
      flip_r <= 1'b0;
    end else if (reload_stb) begin
      mode_r <= mode_d;
      pal_r  <= pal_d;
      flip_r <= flip_d;
    end
  end

  always_ff @(posedge clk) begin
    if (dram_next) data_r <= dram_rdata;
  end

  // Pixel burst: 4 clocks per word in 4bpp, 2 in 8bpp; a new word restarts it.
  assign burst_end = (pcnt == (mode_r ? 2'd1 : 2'd3));

  always_ff @(posedge clk) begin
    if (reset) begin
      run  <= 1'b0;
      pcnt <= 2'd0;
    end else if (dram_next) begin
      run  <= 1'b1;
      pcnt <= 2'd0;
    end else if (run) begin
      pcnt <= pcnt + 2'd1;
      if (burst_end) run <= 1'b0;
    end
  end

  // Address steps on every emitted pixel, transparent or not.
  always_ff @(posedge clk) begin
    if (reset)           ts_waddr <= '0;
    else if (reload_stb) ts_waddr <= x_start;
    else if (run)        ts_waddr <= flip_r ? ts_waddr - XW'(1) : ts_waddr + XW'(1);
  end

  // Leftmost pixel sits in the high nibble / low byte of each bitmap byte / word.
  always_comb begin
    pix4     = 4'd0;
    pix8     = pcnt[0] ? data_r[15:8] : data_r[7:0];
    ts_wdata = 8'd0;
    opaque   = 1'b0;
    case (pcnt)
      2'd0:    pix4 = data_r[7:4];
      2'd1:    pix4 = data_r[3:0];
      2'd2:    pix4 = data_r[15:12];
      default: pix4 = data_r[11:8];
    endcase
    if (mode_r) begin
      ts_wdata = pix8;
      opaque   = (pix8 != TR8);
    end else begin
      ts_wdata = {pal_r, pix4};
      opaque   = (pix4 != TR8[3:0]);
    end
  end

  assign ts_we = run & opaque;

endmodule
